// File: rtl/wb_cmd_master_if.sv
// Command, response and Wishbone-initiator signal bundle for wb_cmd_master.
// The master modport is the wb_cmd_master side; slave is the environment side.
interface wb_cmd_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_ack_i, wbm_dat_i,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_ack_i, wbm_dat_i,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-beat initiator fed from a small command FIFO, with
// a bus-cycle timeout and a valid/ready response port.
module wb_cmd_master #(
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    wb_cmd_master_if.master bus,
    output logic            busy
);
    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CNT_W = $clog2(CMD_DEPTH + 1);
    localparam int TMO_W = $clog2(TIMEOUT);

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    cmd_t             fifo_mem_r [CMD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    state_t           state_r;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic             cyc_r;
    logic             we_r;
    logic [3:0]       sel_r;
    logic [31:0]      adr_r;
    logic [31:0]      dat_r;
    logic             rsp_valid_r;
    logic [31:0]      rsp_dat_r;
    logic             rsp_err_r;

    logic full_s;
    logic empty_s;
    logic push_s;
    logic pop_s;
    cmd_t head_s;
    cmd_t push_cmd_s;

    // A full FIFO refuses a push even when the head is popped in the same cycle.
    assign full_s     = (count_r == CNT_W'(CMD_DEPTH));
    assign empty_s    = (count_r == {CNT_W{1'b0}});
    assign push_s     = bus.cmd_valid & ~full_s;
    assign pop_s      = (state_r == ST_IDLE) & ~empty_s;
    assign head_s     = fifo_mem_r[rd_ptr_r];
    assign push_cmd_s = {bus.cmd_we, bus.cmd_sel, bus.cmd_adr, bus.cmd_dat};

    assign bus.cmd_ready = ~full_s;
    assign bus.wbm_cyc_o = cyc_r;
    assign bus.wbm_stb_o = cyc_r;
    assign bus.wbm_we_o  = we_r;
    assign bus.wbm_sel_o = sel_r;
    assign bus.wbm_adr_o = adr_r;
    assign bus.wbm_dat_o = dat_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_dat   = rsp_dat_r;
    assign bus.rsp_err   = rsp_err_r;
    assign busy          = ~empty_s | (state_r != ST_IDLE);

    // Command FIFO storage, pointers and occupancy count.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < CMD_DEPTH; i++) begin
                fifo_mem_r[i] <= {$bits(cmd_t){1'b0}};
            end
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= push_cmd_s;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Bus-cycle FSM: issue, wait for ack or timeout, then hold the response.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r     <= ST_IDLE;
            tmo_cnt_r   <= {TMO_W{1'b0}};
            cyc_r       <= 1'b0;
            we_r        <= 1'b0;
            sel_r       <= 4'h0;
            adr_r       <= 32'h0;
            dat_r       <= 32'h0;
            rsp_valid_r <= 1'b0;
            rsp_dat_r   <= 32'h0;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        we_r    <= head_s.we;
                        sel_r   <= head_s.sel;
                        adr_r   <= head_s.adr;
                        dat_r   <= head_s.dat;
                        cyc_r   <= 1'b1;
                        state_r <= ST_BUS;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUS: begin
                    // Ack takes priority over a coincident timeout.
                    if (bus.wbm_ack_i) begin
                        cyc_r       <= 1'b0;
                        we_r        <= 1'b0;
                        rsp_dat_r   <= we_r ? 32'h0 : bus.wbm_dat_i;
                        rsp_err_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        tmo_cnt_r   <= {TMO_W{1'b0}};
                        state_r     <= ST_RESP;
                    end else if (tmo_cnt_r == TMO_W'(TIMEOUT - 1)) begin
                        cyc_r       <= 1'b0;
                        we_r        <= 1'b0;
                        rsp_dat_r   <= 32'h0;
                        rsp_err_r   <= 1'b1;
                        rsp_valid_r <= 1'b1;
                        tmo_cnt_r   <= {TMO_W{1'b0}};
                        state_r     <= ST_RESP;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cyc_r       <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    tmo_cnt_r   <= {TMO_W{1'b0}};
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: directed and random commands against a slave model
// whose per-command ack delay defines the expected bus length and response.
module tb_wb_cmd_master;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    wb_cmd_master_if bus ();

    wb_cmd_master #(.CMD_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus     (bus),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // delay: BUS cycle (1-based) on which the slave acks; 0 means never ack
    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          delay;
        logic [31:0] rdata;
    } cmd_t;

    cmd_t        cmd_q[$];
    logic [32:0] rsp_q[$];
    int checks   = 0;
    int failures = 0;
    bit in_reset = 1'b1;
    bit stray_ack = 1'b0;
    bit rand_rsp = 1'b0;
    bit rsp_hold = 1'b0;
    int bus_cnt = 0;
    int exp_len = 0;
    cmd_t cur;

    task automatic check(string tag, logic [71:0] obs, logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit acked(int d);
        return (d >= 1) && (d <= TIMEOUT);
    endfunction

    // Slave model: checks the presented cycle and acks on the planned BUS cycle.
    always @(negedge clk) begin
        if (in_reset) begin
            bus_cnt       = 0;
            bus.wbm_ack_i = 1'b0;
            bus.wbm_dat_i = 32'h0;
        end else if (bus.wbm_cyc_o) begin
            if (bus_cnt == 0) begin
                if (cmd_q.size() == 0) begin
                    check("unexpected_cyc", 72'd1, 72'd0);
                    cur = '{we: 1'b0, adr: 32'h0, dat: 32'h0, sel: 4'h0, delay: 1, rdata: 32'h0};
                end else begin
                    cur = cmd_q.pop_front();
                end
                exp_len = acked(cur.delay) ? cur.delay : TIMEOUT;
                rsp_q.push_back(acked(cur.delay) ? {1'b0, (cur.we ? 32'h0 : cur.rdata)} : {1'b1, 32'h0});
            end
            bus_cnt++;
            check("wbm_stb", bus.wbm_stb_o, 1'b1);
            check("wbm_ctl", {bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o}, {cur.we, cur.sel, cur.adr});
            if (cur.we) check("wbm_dat_o", bus.wbm_dat_o, cur.dat);
            if (bus_cnt > TIMEOUT) check("cyc_overrun", bus_cnt, TIMEOUT);
            bus.wbm_ack_i = (bus_cnt == cur.delay);
            bus.wbm_dat_i = bus.wbm_ack_i ? cur.rdata : $urandom;
        end else begin
            if (bus_cnt != 0) begin
                check("cyc_len", bus_cnt, exp_len);
                bus_cnt = 0;
            end
            bus.wbm_ack_i = stray_ack;
            bus.wbm_dat_i = $urandom;
        end
    end

    // Response consumer: drives rsp_ready and scores each accepted response.
    always @(negedge clk) begin
        bus.rsp_ready = rand_rsp ? ($urandom_range(0, 2) != 0) : rsp_hold;
        if (!in_reset && bus.rsp_valid && bus.rsp_ready) begin
            if (rsp_q.size() == 0) begin
                check("unexpected_rsp", 72'd1, 72'd0);
            end else begin
                check("rsp", {bus.rsp_err, bus.rsp_dat}, rsp_q.pop_front());
            end
        end
    end

    task automatic push(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int delay, input logic [31:0] rdata);
        int guard = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_adr   = adr;
        bus.cmd_dat   = dat;
        bus.cmd_sel   = sel;
        while (!bus.cmd_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            check("push_timeout", 72'd0, 72'd1);
        end else begin
            cmd_q.push_back('{we: we, adr: adr, dat: dat, sel: sel, delay: delay, rdata: rdata});
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((busy || bus.rsp_valid || rsp_q.size() != 0 || cmd_q.size() != 0) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("drain_timeout", guard >= 3000, 1'b0);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = 32'h0;
        bus.cmd_dat   = 32'h0;
        bus.cmd_sel   = 4'h0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outs", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o,
                             bus.wbm_adr_o, bus.rsp_valid, bus.rsp_err, busy}, 72'd0);
        check("reset_data", {bus.wbm_dat_o, bus.rsp_dat}, 72'd0);
        check("reset_cmd_ready", bus.cmd_ready, 1'b1);
        @(negedge clk);
        rst      = 1'b0;
        in_reset = 1'b0;
        rsp_hold = 1'b1;

        // Write acked on the 2nd BUS cycle
        push(1'b1, 32'h3000_0000, 32'h0000_0040, 4'hF, 2, 32'h0);
        wait_idle();

        // Read with fixed slave data, plus push-to-cyc latency
        push(1'b0, 32'h3800_0004, 32'h0, 4'hF, 1, 32'hA5A5_1234);
        check("latency_edge_n", bus.wbm_cyc_o, 1'b0);
        @(posedge clk);
        #1;
        check("latency_edge_n1", bus.wbm_cyc_o, 1'b1);
        wait_idle();

        // Back-pressure: five pushes fill the FIFO behind a held response
        rsp_hold = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(1'b0, 32'h1000_0000 + 32'(i * 4), 32'h0, 4'h3, 1, 32'hC0DE_0000 + 32'(i));
            if (i == 3) check("ready_after_4", bus.cmd_ready, 1'b1);
        end
        check("ready_after_5", bus.cmd_ready, 1'b0);
        check("busy_full", busy, 1'b1);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("blocked_push", bus.cmd_ready, 1'b0);
        end
        bus.cmd_valid = 1'b0;
        rsp_hold = 1'b1;
        push(1'b1, 32'h1000_0100, 32'h5555_AAAA, 4'hC, 3, 32'h0);
        wait_idle();

        // Timeout then a normal command
        push(1'b0, 32'h2000_0000, 32'h0, 4'hF, 0, 32'hDEAD_BEEF);
        push(1'b1, 32'h2000_0004, 32'h1234_0000, 4'h1, 3, 32'h0);
        wait_idle();

        // Ack on the final allowed cycle, then stray acks while idle
        push(1'b0, 32'h2000_0008, 32'h0, 4'hF, TIMEOUT, 32'h1234_5678);
        wait_idle();
        stray_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("stray_ack", {bus.wbm_cyc_o, bus.rsp_valid, busy}, 3'b000);
        end
        stray_ack = 1'b0;

        // Random traffic with random response back-pressure
        rand_rsp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int r;
            int d;
            r = $urandom_range(0, 11);
            d = (r == 0) ? 0 : (r == 1) ? TIMEOUT : (r == 2) ? TIMEOUT + 1 : $urandom_range(1, 5);
            push(1'($urandom), $urandom, $urandom, 4'($urandom), d, $urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();
        rand_rsp = 1'b0;

        // Reset in the middle of a bus cycle
        rsp_hold = 1'b1;
        push(1'b1, 32'h3000_0010, 32'h0BAD_F00D, 4'hF, 0, 32'h0);
        begin
            int guard = 0;
            while (!bus.wbm_cyc_o && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            check("cyc_before_reset", bus.wbm_cyc_o, 1'b1);
        end
        repeat (3) @(negedge clk);
        #2;
        in_reset = 1'b1;
        rst      = 1'b1;
        #1;
        check("rst_mid_bus", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid, busy}, 4'b0000);
        check("rst_mid_ready", bus.cmd_ready, 1'b1);
        cmd_q.delete();
        rsp_q.delete();
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        in_reset = 1'b0;
        push(1'b0, 32'h3000_0020, 32'h0, 4'hF, 2, 32'h7777_1111);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
